secret_scroller: RTL and testbench
==================================

SECRET_SCROLLER -- requirements
Module: secret_scroller

Interface
REQ-001 Parameter WORD_COUNT, default 20, meaning the number of 7-bit message words stored; legal range 2..64.
REQ-002 Parameter DIV, default 1, meaning the number of clocks each output column is held; legal range 1..255.
REQ-003 Parameter ONE_SHOT, default 0, meaning 0 = loop the message endlessly and 1 = play the message once, then blank.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 din  in  7  word input; 7'h7F is the PLAY code, any other value is a LOAD word.
REQ-007 dout  out  8  registered column output.
REQ-008 glyph_code  out  6  combinational font-ROM address (glyph index); equals word[5:0] of the current read word.
REQ-009 glyph_col  out  3  combinational font-ROM column index; equals the current column counter.
REQ-010 glyph_bits  in  8  combinational font-ROM return for (glyph_code, glyph_col).
REQ-011 count  out  clog2(WORD_COUNT+1)  number of valid stored words.
REQ-012 playing  out  1  high while in state PLAY.
REQ-013 wrapped  out  1  one-cycle pulse on the edge that completes the last column of the last stored word.

Function
REQ-014 The block SHALL implement the states IDLE, LOAD, PLAY and DONE.
REQ-015 Storage SHALL be a ring of WORD_COUNT words with write pointer wr_ptr, read pointer rd_ptr and count.
REQ-016 On a LOAD edge (din != 7'h7F) the block SHALL write din to mem[wr_ptr], advance wr_ptr modulo WORD_COUNT, and increment count, saturating at WORD_COUNT.
REQ-017 On a LOAD edge the block SHALL set dout = 0, col = 0, hold counter = 0 and state = LOAD.
REQ-018 When full, a LOAD write SHALL overwrite the oldest word, and the oldest-word pointer SHALL advance with it.
REQ-019 The first LOAD edge following PLAY or DONE SHALL discard the old message: count = 1, the new word is stored as the oldest, and rd_ptr and wr_ptr are rebased.
REQ-020 On a PLAY edge (din == 7'h7F) with count == 0, the block SHALL set dout = 0 and state = IDLE.
REQ-021 The first PLAY edge after LOAD SHALL set rd_ptr to the oldest word and output that word's column 0 on the same edge.
REQ-022 A raw word (bit6 = 0) SHALL be one column: dout = {1'b0, word[5:0], 1'b0}.
REQ-023 A glyph word (bit6 = 1) SHALL be 8 columns, col 0..7: dout = glyph_bits, with glyph_code = word[5:0] and glyph_col = col.
REQ-024 Every column SHALL be held for DIV consecutive PLAY edges, counted by a hold counter 0..DIV-1; dout is reloaded with the same value during the hold.
REQ-025 When the hold and col reach the end of a word, the block SHALL advance rd_ptr to the next stored word and reset col to 0.
REQ-026 When the last stored word completes, the block SHALL pulse wrapped for one cycle.
REQ-027 After the last stored word completes with ONE_SHOT = 0, rd_ptr SHALL wrap to the oldest word.
REQ-028 After the last stored word completes with ONE_SHOT = 1, the block SHALL enter DONE; in DONE, dout = 0 and playing = 0 until a LOAD word arrives.
REQ-029 Leaving PLAY mid-glyph on a LOAD edge SHALL abort the glyph immediately: dout = 0 on that edge, and col and hold are cleared.
REQ-030 Only the count valid words SHALL be played; unwritten locations SHALL never be emitted.
REQ-031 Pointer and column arithmetic SHALL be modulo-exact for non-power-of-two WORD_COUNT, with no out-of-range mem access.

Reset
REQ-032 While rst = 1 at an edge, the block SHALL set dout = 0, count = 0, wr_ptr = 0, rd_ptr = 0, col = 0, hold = 0, playing = 0, wrapped = 0 and state = IDLE.
REQ-033 Memory contents SHALL NOT require reset; they are unreachable while count = 0.
REQ-034 rst SHALL take priority over din on the same edge, including a reset asserted mid-glyph or mid-hold.

Verification
Bench ROM stub: glyph_bits = {glyph_code[4:0], glyph_col}.
REQ-035 Reset: hold rst for 2 edges with din = 7'h7F -> dout = 0x00, count = 0, playing = 0, wrapped never high.
REQ-036 Raw loop: DIV = 1; load 0x05, 0x0A, then PLAY -> dout = 0x0A, 0x14, 0x0A, 0x14..., with wrapped high on every 2nd PLAY edge.
REQ-037 Glyph and hold: DIV = 2; load 0x41, then PLAY -> dout = 0x08, 0x08, 0x09, 0x09, ..., 0x0F, 0x0F (16 edges), then repeats; wrapped high on the 16th edge.
REQ-038 Overflow: WORD_COUNT = 4; load 0x01..0x06 -> count = 4; PLAY dout = 0x06, 0x08, 0x0A, 0x0C, then 0x06.
REQ-039 One-shot: ONE_SHOT = 1; load 0x03, then PLAY for 5 edges -> dout = 0x06, then 0x00; playing falls after edge 1; wrapped pulses exactly once.
REQ-040 Abort and rebase: mid-glyph, a LOAD of 0x02 -> dout = 0 on that edge, count = 1; the next PLAY outputs 0x04 repeatedly; rst asserted mid-glyph -> count = 0 and dout = 0 on the next edge.

Source files
------------

// File: rtl/secret_scroller.sv
// secret_scroller
// ---------------
// Stores a short message of 7-bit words in a ring buffer and plays it back
// one column at a time on an 8-bit output. A word with bit 6 clear is a raw
// column: dout = {1'b0, word[5:0], 1'b0}. A word with bit 6 set is a glyph of
// eight columns, fetched from an external combinational font ROM through
// glyph_code/glyph_col/glyph_bits. Every column is held for DIV clocks.
//
// din == 7'h7F is the PLAY code. Any other din value is a word to store.
// The first word stored after playback has started throws away the old
// message. With ONE_SHOT = 1 the message plays once and the output then
// stays blank until a new word arrives.
//
// Parameters
//   WORD_COUNT  ring depth in words (2..64)
//   DIV         clocks per column (1..255)
//   ONE_SHOT    0 = loop forever, 1 = play once, then blank
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset, beats din on the same edge
//   din         7-bit word in; 7'h7F = PLAY, anything else = LOAD
//   dout        registered column output
//   glyph_code  font-ROM glyph index (word[5:0] of the word being read)
//   glyph_col   font-ROM column index (current column counter)
//   glyph_bits  font-ROM return for (glyph_code, glyph_col)
//   count       number of valid stored words
//   playing     high while in state PLAY
//   wrapped     one-clock pulse on the edge that emits the final hold of
//               the final column of the last stored word

module secret_scroller #(
  parameter int WORD_COUNT = 20,
  parameter int DIV        = 1,
  parameter int ONE_SHOT   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [6:0]                        din,
  output logic [7:0]                        dout,
  output logic [5:0]                        glyph_code,
  output logic [2:0]                        glyph_col,
  input  logic [7:0]                        glyph_bits,
  output logic [$clog2(WORD_COUNT+1)-1:0]   count,
  output logic                              playing,
  output logic                              wrapped
);

  localparam int PTR_W  = $clog2(WORD_COUNT);
  localparam int CNT_W  = $clog2(WORD_COUNT + 1);
  localparam int HOLD_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(WORD_COUNT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORD_COUNT);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(DIV - 1);
  localparam logic [6:0]        PLAY_CODE = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // Ring storage. head is the oldest valid word, wr_ptr the next free slot,
  // so the newest word always sits one behind wr_ptr.
  logic [6:0]        mem [WORD_COUNT];
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nx;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_nx;
  logic [PTR_W-1:0]  head, head_nx;
  logic [CNT_W-1:0]  count_nx;

  logic [2:0]        col, col_nx;
  logic [HOLD_W-1:0] hold, hold_nx;
  logic [7:0]        dout_nx;
  logic              wrapped_nx;

  // Set on the edge that emits the last slot of a one-shot pass; the next
  // PLAY edge then blanks the output and parks in DONE.
  logic              finished, finished_nx;

  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [6:0]        mem_wdata;

  logic              is_play;
  logic              in_play;
  logic              rebase;
  logic [PTR_W-1:0]  cur_ptr;
  logic [6:0]        cur_word;
  logic [2:0]        cur_col;
  logic [HOLD_W-1:0] cur_hold;
  logic [PTR_W-1:0]  last_ptr;
  logic              col_end;
  logic              hold_end;

  // Modulo increment that stays exact for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  // Read-side view of the slot being emitted on this edge. On the first
  // PLAY edge after loading we are still in LOAD, so the position comes
  // from the oldest word at column 0 / hold 0 instead of the registers.
  always_comb begin
    is_play  = (din == PLAY_CODE);
    in_play  = (state == S_PLAY);
    rebase   = (state == S_PLAY) || (state == S_DONE);
    cur_ptr  = in_play ? rd_ptr : head;
    cur_word = mem[cur_ptr];
    cur_col  = in_play ? col  : 3'd0;
    cur_hold = in_play ? hold : '0;
    last_ptr = (wr_ptr == '0) ? PTR_MAX : wr_ptr - PTR_W'(1);
    col_end  = cur_word[6] ? (cur_col == 3'd7) : 1'b1;
    hold_end = (cur_hold == HOLD_MAX);
  end

  assign glyph_code = cur_word[5:0];
  assign glyph_col  = cur_col;
  assign playing    = (state == S_PLAY);

  // Next-state and datapath decisions for one edge.
  always_comb begin
    state_nx    = state;
    wr_ptr_nx   = wr_ptr;
    rd_ptr_nx   = rd_ptr;
    head_nx     = head;
    count_nx    = count;
    col_nx      = col;
    hold_nx     = hold;
    dout_nx     = dout;
    wrapped_nx  = 1'b0;
    finished_nx = finished;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr;
    mem_wdata   = din;

    if (!is_play) begin
      mem_we      = 1'b1;
      state_nx    = S_LOAD;
      dout_nx     = 8'h00;
      col_nx      = 3'd0;
      hold_nx     = '0;
      finished_nx = 1'b0;
      if (rebase) begin
        // A new message starts over at slot 0 as its only word.
        mem_waddr = '0;
        head_nx   = '0;
        rd_ptr_nx = '0;
        wr_ptr_nx = ptr_inc('0);
        count_nx  = CNT_W'(1);
      end else begin
        wr_ptr_nx = ptr_inc(wr_ptr);
        if (count == CNT_FULL) begin
          head_nx = ptr_inc(head);
        end else begin
          count_nx = count + CNT_W'(1);
        end
      end
    end else if (count == '0) begin
      state_nx = S_IDLE;
      dout_nx  = 8'h00;
      col_nx   = 3'd0;
      hold_nx  = '0;
    end else if ((state == S_DONE) || (in_play && finished)) begin
      state_nx = S_DONE;
      dout_nx  = 8'h00;
      col_nx   = 3'd0;
      hold_nx  = '0;
    end else begin
      state_nx  = S_PLAY;
      dout_nx   = cur_word[6] ? glyph_bits : {1'b0, cur_word[5:0], 1'b0};
      rd_ptr_nx = cur_ptr;
      col_nx    = cur_col;
      if (!hold_end) begin
        hold_nx = cur_hold + HOLD_W'(1);
      end else begin
        hold_nx = '0;
        if (!col_end) begin
          col_nx = cur_col + 3'd1;
        end else begin
          col_nx = 3'd0;
          if (cur_ptr == last_ptr) begin
            rd_ptr_nx   = head;
            wrapped_nx  = 1'b1;
            finished_nx = (ONE_SHOT != 0);
          end else begin
            rd_ptr_nx = ptr_inc(cur_ptr);
          end
        end
      end
    end
  end

  // State register. Reset wins over any din activity on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head     <= '0;
      count    <= '0;
      col      <= 3'd0;
      hold     <= '0;
      dout     <= 8'h00;
      wrapped  <= 1'b0;
      finished <= 1'b0;
    end else begin
      state    <= state_nx;
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      head     <= head_nx;
      count    <= count_nx;
      col      <= col_nx;
      hold     <= hold_nx;
      dout     <= dout_nx;
      wrapped  <= wrapped_nx;
      finished <= finished_nx;
    end
  end

  // Message memory has no reset; nothing is read back while count is 0.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_secret_scroller.sv
// Testbench for secret_scroller. Three instances with different parameter
// sets share one stimulus stream; each is compared edge by edge against a
// message-level reference model that treats playback as a flat list of
// output slots.
//   A: WORD_COUNT=20 DIV=1 ONE_SHOT=0
//   B: WORD_COUNT=4  DIV=2 ONE_SHOT=0
//   C: WORD_COUNT=3  DIV=1 ONE_SHOT=1
// Font ROM stub: glyph_bits = {glyph_code[4:0], glyph_col}.

module tb_secret_scroller;

  localparam int NDUT = 3;
  localparam int WC_A = 20, DIV_A = 1, OS_A = 0;
  localparam int WC_B = 4,  DIV_B = 2, OS_B = 0;
  localparam int WC_C = 3,  DIV_C = 1, OS_C = 1;
  localparam int P_WC  [NDUT] = '{WC_A, WC_B, WC_C};
  localparam int P_DIV [NDUT] = '{DIV_A, DIV_B, DIV_C};
  localparam int P_OS  [NDUT] = '{OS_A, OS_B, OS_C};

  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [6:0] din = 7'h7F;

  logic [7:0] dout_a, dout_b, dout_c;
  logic [5:0] gcode_a, gcode_b, gcode_c;
  logic [2:0] gcol_a, gcol_b, gcol_c;
  logic [7:0] gbits_a, gbits_b, gbits_c;
  logic [4:0] count_a;
  logic [2:0] count_b;
  logic [1:0] count_c;
  logic       play_a, play_b, play_c;
  logic       wrap_a, wrap_b, wrap_c;

  assign gbits_a = {gcode_a[4:0], gcol_a};
  assign gbits_b = {gcode_b[4:0], gcol_b};
  assign gbits_c = {gcode_c[4:0], gcol_c};

  secret_scroller #(.WORD_COUNT(WC_A), .DIV(DIV_A), .ONE_SHOT(OS_A)) u_a (
    .clk(clk), .rst(rst), .din(din), .dout(dout_a),
    .glyph_code(gcode_a), .glyph_col(gcol_a), .glyph_bits(gbits_a),
    .count(count_a), .playing(play_a), .wrapped(wrap_a));

  secret_scroller #(.WORD_COUNT(WC_B), .DIV(DIV_B), .ONE_SHOT(OS_B)) u_b (
    .clk(clk), .rst(rst), .din(din), .dout(dout_b),
    .glyph_code(gcode_b), .glyph_col(gcol_b), .glyph_bits(gbits_b),
    .count(count_b), .playing(play_b), .wrapped(wrap_b));

  secret_scroller #(.WORD_COUNT(WC_C), .DIV(DIV_C), .ONE_SHOT(OS_C)) u_c (
    .clk(clk), .rst(rst), .din(din), .dout(dout_c),
    .glyph_code(gcode_c), .glyph_col(gcol_c), .glyph_bits(gbits_c),
    .count(count_c), .playing(play_c), .wrapped(wrap_c));

  // Observed outputs gathered into arrays so every test can loop over DUTs.
  logic [7:0] obs_dout  [NDUT];
  logic [6:0] obs_count [NDUT];
  logic       obs_play  [NDUT];
  logic       obs_wrap  [NDUT];

  always_comb begin
    obs_dout[0]  = dout_a;
    obs_dout[1]  = dout_b;
    obs_dout[2]  = dout_c;
    obs_count[0] = 7'(count_a);
    obs_count[1] = 7'(count_b);
    obs_count[2] = 7'(count_c);
    obs_play[0]  = play_a;
    obs_play[1]  = play_b;
    obs_play[2]  = play_c;
    obs_wrap[0]  = wrap_a;
    obs_wrap[1]  = wrap_b;
    obs_wrap[2]  = wrap_c;
  end

  // Reference model: the message as an ordered list (oldest first), a mode,
  // and the index of the next slot in the expanded column sequence.
  logic [6:0] mw [NDUT][64];
  int         mlen  [NDUT];
  int         mmode [NDUT];
  int         mslot [NDUT];
  bit         mfin  [NDUT];
  logic [7:0] exp_dout [NDUT];
  logic       exp_wrap [NDUT];
  logic       exp_play [NDUT];
  int         wrap_seen [NDUT];

  int errors = 0;
  int checks = 0;

  function automatic int word_cols(input logic [6:0] w);
    return w[6] ? 8 : 1;
  endfunction

  task automatic model_edge(input int k, input logic r, input logic [6:0] d);
    int total;
    int s;
    int n;
    int c;
    bit found;
    logic [6:0] w;
    exp_wrap[k] = 1'b0;
    if (r) begin
      mlen[k] = 0; mmode[k] = M_IDLE; mfin[k] = 0;
      exp_dout[k] = 8'h00; exp_play[k] = 1'b0;
    end else if (d != 7'h7F) begin
      if (mmode[k] == M_PLAY || mmode[k] == M_DONE) mlen[k] = 0;
      if (mlen[k] == P_WC[k]) begin
        for (int i = 0; i < mlen[k] - 1; i++) mw[k][i] = mw[k][i+1];
        mlen[k]--;
      end
      mw[k][mlen[k]] = d;
      mlen[k]++;
      mmode[k] = M_LOAD; mfin[k] = 0;
      exp_dout[k] = 8'h00; exp_play[k] = 1'b0;
    end else if (mlen[k] == 0) begin
      mmode[k] = M_IDLE; exp_dout[k] = 8'h00; exp_play[k] = 1'b0;
    end else if (mmode[k] == M_DONE || (mmode[k] == M_PLAY && mfin[k])) begin
      mmode[k] = M_DONE; exp_dout[k] = 8'h00; exp_play[k] = 1'b0;
    end else begin
      if (mmode[k] != M_PLAY) mslot[k] = 0;
      total = 0;
      for (int i = 0; i < mlen[k]; i++) total += word_cols(mw[k][i]) * P_DIV[k];
      s = mslot[k]; w = mw[k][0]; c = 0; found = 0;
      for (int i = 0; i < mlen[k]; i++) begin
        n = word_cols(mw[k][i]) * P_DIV[k];
        if (!found) begin
          if (s < n) begin
            w = mw[k][i]; c = s / P_DIV[k]; found = 1;
          end else begin
            s -= n;
          end
        end
      end
      exp_dout[k] = w[6] ? {w[4:0], 3'(c)} : {1'b0, w[5:0], 1'b0};
      if (mslot[k] == total - 1) begin
        exp_wrap[k] = 1'b1;
        if (P_OS[k] != 0) mfin[k] = 1;
      end
      mslot[k] = (mslot[k] + 1) % total;
      mmode[k] = M_PLAY; exp_play[k] = 1'b1;
    end
  endtask

  // Drive one edge: inputs change on the falling edge, outputs are sampled
  // 1 time unit after the rising edge, and the model advances in step.
  task automatic step(input logic r, input logic [6:0] d);
    @(negedge clk);
    rst = r;
    din = d;
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      model_edge(k, r, d);
      if (obs_wrap[k] === 1'b1) wrap_seen[k]++;
    end
  endtask

  task automatic test_reset();
    for (int e = 0; e < 2; e++) begin
      step(1'b1, 7'h7F);
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_dout[k] !== 8'h00) begin
          errors++; $display("[TB] FAIL reset dout dut%0d: got %02h expected 00", k, obs_dout[k]);
        end
        checks++;
        if (obs_count[k] !== 7'd0) begin
          errors++; $display("[TB] FAIL reset count dut%0d: got %0d expected 0", k, obs_count[k]);
        end
        checks++;
        if (obs_play[k] !== 1'b0 || obs_wrap[k] !== 1'b0) begin
          errors++; $display("[TB] FAIL reset flags dut%0d: got play=%b wrap=%b expected 0/0", k, obs_play[k], obs_wrap[k]);
        end
      end
    end
  endtask

  task automatic test_raw_loop();
    logic [7:0] seq [2];
    seq[0] = 8'h0A;
    seq[1] = 8'h14;
    step(1'b0, 7'h05);
    step(1'b0, 7'h0A);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 7'h7F);
      checks++;
      if (obs_dout[0] !== seq[i % 2] || obs_wrap[0] !== (i % 2 == 1)) begin
        errors++; $display("[TB] FAIL raw_loop literal edge %0d: got dout=%02h wrap=%b expected dout=%02h wrap=%b", i, obs_dout[0], obs_wrap[0], seq[i % 2], (i % 2 == 1));
      end
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_dout[k] !== exp_dout[k] || obs_wrap[k] !== exp_wrap[k] || obs_play[k] !== exp_play[k] || obs_count[k] !== 7'(mlen[k])) begin
          errors++; $display("[TB] FAIL raw_loop dut%0d edge %0d: got dout=%02h wrap=%b play=%b count=%0d expected dout=%02h wrap=%b play=%b count=%0d", k, i, obs_dout[k], obs_wrap[k], obs_play[k], obs_count[k], exp_dout[k], exp_wrap[k], exp_play[k], mlen[k]);
        end
      end
    end
  endtask

  task automatic test_glyph_hold();
    logic [7:0] want;
    step(1'b0, 7'h41);
    for (int i = 0; i < 34; i++) begin
      step(1'b0, 7'h7F);
      want = 8'h08 + 8'((i % 16) / 2);
      checks++;
      if (obs_dout[1] !== want || obs_wrap[1] !== (i % 16 == 15)) begin
        errors++; $display("[TB] FAIL glyph_hold literal edge %0d: got dout=%02h wrap=%b expected dout=%02h wrap=%b", i, obs_dout[1], obs_wrap[1], want, (i % 16 == 15));
      end
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_dout[k] !== exp_dout[k] || obs_wrap[k] !== exp_wrap[k] || obs_play[k] !== exp_play[k] || obs_count[k] !== 7'(mlen[k])) begin
          errors++; $display("[TB] FAIL glyph_hold dut%0d edge %0d: got dout=%02h wrap=%b play=%b count=%0d expected dout=%02h wrap=%b play=%b count=%0d", k, i, obs_dout[k], obs_wrap[k], obs_play[k], obs_count[k], exp_dout[k], exp_wrap[k], exp_play[k], mlen[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] want;
    for (int v = 1; v <= 6; v++) step(1'b0, 7'(v));
    checks++;
    if (obs_count[1] !== 7'd4) begin
      errors++; $display("[TB] FAIL overflow count: got %0d expected 4", obs_count[1]);
    end
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 7'h7F);
      want = 8'h06 + 8'(2 * ((i / 2) % 4));
      checks++;
      if (obs_dout[1] !== want) begin
        errors++; $display("[TB] FAIL overflow literal edge %0d: got %02h expected %02h", i, obs_dout[1], want);
      end
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_dout[k] !== exp_dout[k] || obs_wrap[k] !== exp_wrap[k] || obs_play[k] !== exp_play[k] || obs_count[k] !== 7'(mlen[k])) begin
          errors++; $display("[TB] FAIL overflow dut%0d edge %0d: got dout=%02h wrap=%b play=%b count=%0d expected dout=%02h wrap=%b play=%b count=%0d", k, i, obs_dout[k], obs_wrap[k], obs_play[k], obs_count[k], exp_dout[k], exp_wrap[k], exp_play[k], mlen[k]);
        end
      end
    end
  endtask

  task automatic test_one_shot();
    step(1'b0, 7'h03);
    wrap_seen[2] = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 7'h7F);
      checks++;
      if (obs_dout[2] !== ((i == 0) ? 8'h06 : 8'h00) || obs_play[2] !== (i == 0)) begin
        errors++; $display("[TB] FAIL one_shot literal edge %0d: got dout=%02h play=%b expected dout=%02h play=%b", i, obs_dout[2], obs_play[2], (i == 0) ? 8'h06 : 8'h00, (i == 0));
      end
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_dout[k] !== exp_dout[k] || obs_wrap[k] !== exp_wrap[k] || obs_play[k] !== exp_play[k] || obs_count[k] !== 7'(mlen[k])) begin
          errors++; $display("[TB] FAIL one_shot dut%0d edge %0d: got dout=%02h wrap=%b play=%b count=%0d expected dout=%02h wrap=%b play=%b count=%0d", k, i, obs_dout[k], obs_wrap[k], obs_play[k], obs_count[k], exp_dout[k], exp_wrap[k], exp_play[k], mlen[k]);
        end
      end
    end
    checks++;
    if (wrap_seen[2] != 1) begin
      errors++; $display("[TB] FAIL one_shot wrap pulses: got %0d expected 1", wrap_seen[2]);
    end
  endtask

  task automatic test_abort_rebase();
    step(1'b0, 7'h41);
    step(1'b0, 7'h42);
    for (int i = 0; i < 5; i++) step(1'b0, 7'h7F);
    step(1'b0, 7'h02);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (obs_dout[k] !== 8'h00 || obs_count[k] !== 7'd1 || obs_play[k] !== 1'b0) begin
        errors++; $display("[TB] FAIL abort dut%0d: got dout=%02h count=%0d play=%b expected dout=00 count=1 play=0", k, obs_dout[k], obs_count[k], obs_play[k]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 7'h7F);
      checks++;
      if (obs_dout[0] !== 8'h04) begin
        errors++; $display("[TB] FAIL rebase edge %0d: got %02h expected 04", i, obs_dout[0]);
      end
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_dout[k] !== exp_dout[k] || obs_wrap[k] !== exp_wrap[k] || obs_play[k] !== exp_play[k]) begin
          errors++; $display("[TB] FAIL rebase dut%0d edge %0d: got dout=%02h wrap=%b play=%b expected dout=%02h wrap=%b play=%b", k, i, obs_dout[k], obs_wrap[k], obs_play[k], exp_dout[k], exp_wrap[k], exp_play[k]);
        end
      end
    end
    step(1'b0, 7'h43);
    for (int i = 0; i < 3; i++) step(1'b0, 7'h7F);
    step(1'b1, 7'h7F);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (obs_dout[k] !== 8'h00 || obs_count[k] !== 7'd0 || obs_play[k] !== 1'b0) begin
        errors++; $display("[TB] FAIL mid_glyph_reset dut%0d: got dout=%02h count=%0d play=%b expected 00/0/0", k, obs_dout[k], obs_count[k], obs_play[k]);
      end
    end
    step(1'b0, 7'h7F);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (obs_dout[k] !== 8'h00 || obs_play[k] !== 1'b0) begin
        errors++; $display("[TB] FAIL empty_play dut%0d: got dout=%02h play=%b expected 00/0", k, obs_dout[k], obs_play[k]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [6:0] d;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        step(1'b1, 7'h7F);
      end else if (r < 70) begin
        step(1'b0, 7'h7F);
      end else begin
        d = 7'($urandom_range(0, 126));
        step(1'b0, d);
      end
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_dout[k] !== exp_dout[k] || obs_wrap[k] !== exp_wrap[k] || obs_play[k] !== exp_play[k] || obs_count[k] !== 7'(mlen[k])) begin
          errors++; $display("[TB] FAIL random dut%0d edge %0d: got dout=%02h wrap=%b play=%b count=%0d expected dout=%02h wrap=%b play=%b count=%0d", k, i, obs_dout[k], obs_wrap[k], obs_play[k], obs_count[k], exp_dout[k], exp_wrap[k], exp_play[k], mlen[k]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      mlen[k] = 0; mmode[k] = M_IDLE; mslot[k] = 0; mfin[k] = 0;
      exp_dout[k] = 8'h00; exp_wrap[k] = 1'b0; exp_play[k] = 1'b0;
      wrap_seen[k] = 0;
    end
    test_reset();
    test_raw_loop();
    test_glyph_hold();
    test_overflow();
    test_one_shot();
    test_abort_rebase();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
